// File: rtl/rx_control.sv
// rtl/rx_control.sv - UART receiver: 8N1 frames (8E1 when RX_PARITY_EN is defined) to a valid/ready byte port.
// Optional feature macro: RX_PARITY_EN.
module rx_control #(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   input  logic       rx_rdy,
   output logic [7:0] rx_data,
   output logic       rx_vld,
   output logic       rx_busy,
   output logic       rx_frame_err,
   output logic       rx_overrun,
   output logic       rx_parity_err
);

   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;
   localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
   localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

`ifdef RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t      state_q, state_d;
   logic        meta_q, rxs_q, rxs_prev_q;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        vld_q, vld_d;
   logic        ferr_q, ferr_d;
   logic        ovr_q, ovr_d;
   logic        restart;
`ifdef RX_PARITY_EN
   logic        par_bad_q, par_bad_d;
   logic        perr_q, perr_d;
`endif

   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      vld_d     = vld_q && !rx_rdy;
      ferr_d    = 1'b0;
      ovr_d     = 1'b0;
      restart   = 1'b0;
`ifdef RX_PARITY_EN
      par_bad_d = par_bad_q;
      perr_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (rxs_prev_q && !rxs_q) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               state_d   = rxs_q ? S_IDLE : S_DATA;
               bit_idx_d = 3'd0;
            end
         end
         S_DATA: begin
            // Each data bit restarts the bit timer without leaving the state.
            if (cnt_q == DIV_M1) begin
               shift_d   = {rxs_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               restart   = 1'b1;
               if (bit_idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == DIV_M1) begin
               par_bad_d = rxs_q ^ (^shift_q);
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            // Leave at mid-stop so a directly following start edge is seen.
            if (cnt_q == DIV_M1) begin
               state_d = S_IDLE;
               if (!rxs_q) begin
                  ferr_d = 1'b1;
`ifdef RX_PARITY_EN
               end else if (par_bad_q) begin
                  perr_d = 1'b1;
`endif
               end else if (vld_q && !rx_rdy) begin
                  ovr_d = 1'b1;
               end else begin
                  data_d = shift_q;
                  vld_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      cnt_d = ((state_d != state_q) || restart) ? 16'd0 : cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q     <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'h00;
         data_q     <= 8'h00;
         vld_q      <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
`ifdef RX_PARITY_EN
         par_bad_q  <= 1'b0;
         perr_q     <= 1'b0;
`endif
      end else begin
         meta_q     <= uart_rx;
         rxs_q      <= meta_q;
         rxs_prev_q <= rxs_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         vld_q      <= vld_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
`ifdef RX_PARITY_EN
         par_bad_q  <= par_bad_d;
         perr_q     <= perr_d;
`endif
      end
   end

   assign rx_data      = data_q;
   assign rx_vld       = vld_q;
   assign rx_busy      = (state_q != S_IDLE);
   assign rx_frame_err = ferr_q;
   assign rx_overrun   = ovr_q;
`ifdef RX_PARITY_EN
   assign rx_parity_err = perr_q;
`else
   assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_control.sv
// tb/tb_rx_control.sv - directed self-checking bench for rx_control at DIV=10, HALF=5.
module tb_rx_control;

   localparam int DIV  = 10;
   localparam int HALF = 5;
`ifdef RX_PARITY_EN
   localparam bit HAS_PAR = 1'b1;
`else
   localparam bit HAS_PAR = 1'b0;
`endif
   localparam int FRAME_BITS = HAS_PAR ? 11 : 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       uart_rx = 1'b1;
   logic       rx_rdy = 1'b0;
   logic [7:0] rx_data;
   logic       rx_vld, rx_busy, rx_frame_err, rx_overrun, rx_parity_err;

   int checks = 0;
   int errors = 0;

   int vld_cyc = 0, busy_cyc = 0, ferr_cyc = 0, ovr_cyc = 0, perr_cyc = 0;
   logic [7:0] got_q[$];

   rx_control #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
      .clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_rdy(rx_rdy),
      .rx_data(rx_data), .rx_vld(rx_vld), .rx_busy(rx_busy),
      .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
      .rx_parity_err(rx_parity_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_vld) vld_cyc++;
      if (rx_busy) busy_cyc++;
      if (rx_frame_err) ferr_cyc++;
      if (rx_overrun) ovr_cyc++;
      if (rx_parity_err) perr_cyc++;
      if (rx_vld && rx_rdy) got_q.push_back(rx_data);
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      uart_rx = b;
      idle(DIV);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (HAS_PAR) drive_bit((^d) ^ par_flip);
      drive_bit(stop_bit);
      uart_rx = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(3);
      checks++;
      if ({rx_vld, rx_busy, rx_frame_err, rx_overrun, rx_parity_err, rx_data} !== 13'h0) begin
         errors++;
         $display("FAIL reset_outputs got vld=%b busy=%b fe=%b ov=%b pe=%b data=%h want all 0",
                  rx_vld, rx_busy, rx_frame_err, rx_overrun, rx_parity_err, rx_data);
      end
      rst = 1'b0;
      idle(5);
      checks++;
      if (rx_busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_busy got %b want 0", rx_busy);
      end
   endtask

   task automatic test_basic;
      int n0, v0, f0, o0, lat;
      bit seen;
      n0 = got_q.size(); v0 = vld_cyc; f0 = ferr_cyc; o0 = ovr_cyc;
      rx_rdy = 1'b1;
      lat = 0; seen = 1'b0;
      fork
         send_frame(8'hA5, 1'b1, 1'b0);
         begin
            while (!seen && lat < 200) begin
               @(posedge clk);
               lat++;
               @(negedge clk);
               if (rx_vld) seen = 1'b1;
            end
         end
      join
      idle(5);
      checks++;
      if (lat !== HALF + 3 + (FRAME_BITS - 1) * DIV) begin
         errors++;
         $display("FAIL basic_latency got %0d want %0d", lat, HALF + 3 + (FRAME_BITS - 1) * DIV);
      end
      checks++;
      if (got_q.size() !== n0 + 1) begin
         errors++;
         $display("FAIL basic_count got %0d want %0d", got_q.size() - n0, 1);
      end else begin
         checks++;
         if (got_q[n0] !== 8'hA5) begin
            errors++;
            $display("FAIL basic_data got %h want a5", got_q[n0]);
         end
      end
      checks++;
      if (vld_cyc - v0 !== 1) begin
         errors++;
         $display("FAIL basic_vld_width got %0d want 1", vld_cyc - v0);
      end
      checks++;
      if ((ferr_cyc - f0) + (ovr_cyc - o0) !== 0) begin
         errors++;
         $display("FAIL basic_flags got %0d want 0", (ferr_cyc - f0) + (ovr_cyc - o0));
      end
   endtask

   task automatic test_overrun;
      int n0, o0;
      n0 = got_q.size(); o0 = ovr_cyc;
      rx_rdy = 1'b0;
      send_frame(8'h3C, 1'b1, 1'b0);
      send_frame(8'hC3, 1'b1, 1'b0);
      idle(5);
      checks++;
      if (ovr_cyc - o0 !== 1) begin
         errors++;
         $display("FAIL overrun_pulse got %0d want 1", ovr_cyc - o0);
      end
      checks++;
      if (rx_vld !== 1'b1 || rx_data !== 8'h3C) begin
         errors++;
         $display("FAIL overrun_held got vld=%b data=%h want vld=1 data=3c", rx_vld, rx_data);
      end
      rx_rdy = 1'b1;
      idle(3);
      checks++;
      if (got_q.size() !== n0 + 1 || got_q[got_q.size() - 1] !== 8'h3C) begin
         errors++;
         $display("FAIL overrun_accept got n=%0d want n=1 data=3c", got_q.size() - n0);
      end
      checks++;
      if (rx_vld !== 1'b0) begin
         errors++;
         $display("FAIL overrun_vld_clear got %b want 0", rx_vld);
      end
   endtask

   task automatic test_frame_err;
      int n0, v0, f0;
      n0 = got_q.size(); v0 = vld_cyc; f0 = ferr_cyc;
      rx_rdy = 1'b1;
      send_frame(8'h55, 1'b0, 1'b0);
      idle(10);
      checks++;
      if (ferr_cyc - f0 !== 1) begin
         errors++;
         $display("FAIL frame_err_pulse got %0d want 1", ferr_cyc - f0);
      end
      checks++;
      if (vld_cyc - v0 !== 0) begin
         errors++;
         $display("FAIL frame_err_vld got %0d want 0", vld_cyc - v0);
      end
      send_frame(8'h12, 1'b1, 1'b0);
      idle(5);
      checks++;
      if (got_q.size() !== n0 + 1 || got_q[got_q.size() - 1] !== 8'h12) begin
         errors++;
         $display("FAIL frame_err_recover got n=%0d want n=1 data=12", got_q.size() - n0);
      end
   endtask

   task automatic test_glitch;
      int b0, v0, f0, o0;
      b0 = busy_cyc; v0 = vld_cyc; f0 = ferr_cyc; o0 = ovr_cyc;
      uart_rx = 1'b0;
      idle(3);
      uart_rx = 1'b1;
      idle(30);
      checks++;
      if (busy_cyc - b0 !== HALF) begin
         errors++;
         $display("FAIL glitch_busy got %0d want %0d", busy_cyc - b0, HALF);
      end
      checks++;
      if ((vld_cyc - v0) + (ferr_cyc - f0) + (ovr_cyc - o0) !== 0) begin
         errors++;
         $display("FAIL glitch_flags got %0d want 0", (vld_cyc - v0) + (ferr_cyc - f0) + (ovr_cyc - o0));
      end
   endtask

   task automatic test_back_to_back;
      int n0, o0;
      logic [7:0] exp [3];
      exp[0] = 8'h01; exp[1] = 8'h80; exp[2] = 8'hFF;
      n0 = got_q.size(); o0 = ovr_cyc;
      rx_rdy = 1'b1;
      for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, 1'b0);
      idle(5);
      checks++;
      if (got_q.size() !== n0 + 3) begin
         errors++;
         $display("FAIL b2b_count got %0d want 3", got_q.size() - n0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_q[n0 + i] !== exp[i]) begin
               errors++;
               $display("FAIL b2b_data%0d got %h want %h", i, got_q[n0 + i], exp[i]);
            end
         end
      end
      checks++;
      if (ovr_cyc - o0 !== 0) begin
         errors++;
         $display("FAIL b2b_overrun got %0d want 0", ovr_cyc - o0);
      end
   endtask

   task automatic test_reset_mid;
      int n0;
      rx_rdy = 1'b1;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      idle(5);
      checks++;
      if (rx_busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_busy_before got %b want 1", rx_busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({rx_vld, rx_busy, rx_frame_err, rx_overrun, rx_parity_err, rx_data} !== 13'h0) begin
         errors++;
         $display("FAIL rst_mid_outputs got busy=%b vld=%b data=%h want all 0", rx_busy, rx_vld, rx_data);
      end
      idle(3);
      rst = 1'b0;
      idle(5);
      n0 = got_q.size();
      send_frame(8'h81, 1'b1, 1'b0);
      idle(5);
      checks++;
      if (got_q.size() !== n0 + 1 || got_q[got_q.size() - 1] !== 8'h81) begin
         errors++;
         $display("FAIL rst_mid_recover got n=%0d want n=1 data=81", got_q.size() - n0);
      end
   endtask

   task automatic test_parity;
`ifdef RX_PARITY_EN
      int n0, v0, p0;
      rx_rdy = 1'b1;
      n0 = got_q.size(); p0 = perr_cyc;
      send_frame(8'h07, 1'b1, 1'b0);
      idle(5);
      checks++;
      if (got_q.size() !== n0 + 1 || got_q[got_q.size() - 1] !== 8'h07 || perr_cyc - p0 !== 0) begin
         errors++;
         $display("FAIL parity_good got n=%0d perr=%0d want n=1 perr=0", got_q.size() - n0, perr_cyc - p0);
      end
      v0 = vld_cyc; p0 = perr_cyc;
      send_frame(8'h07, 1'b1, 1'b1);
      idle(5);
      checks++;
      if (perr_cyc - p0 !== 1) begin
         errors++;
         $display("FAIL parity_err_pulse got %0d want 1", perr_cyc - p0);
      end
      checks++;
      if (vld_cyc - v0 !== 0) begin
         errors++;
         $display("FAIL parity_err_vld got %0d want 0", vld_cyc - v0);
      end
`else
      checks++;
      if (perr_cyc !== 0) begin
         errors++;
         $display("FAIL parity_tied got %0d want 0", perr_cyc);
      end
`endif
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset;
      test_basic;
      test_overrun;
      test_frame_err;
      test_glitch;
      test_back_to_back;
      test_reset_mid;
      test_parity;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
